// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer geometry, widths and fill FSM state encoding
package fb_pkg;

    localparam int H_RES  = 640;
    localparam int V_RES  = 480;
    localparam int ADDR_W = 19;
    localparam int DATA_W = 32;
    localparam int X_W    = 10;
    localparam int Y_W    = 9;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_SETUP,
        FILL_RUN,
        FILL_DONE
    } fill_state_e;

    // Linear framebuffer address of pixel (x, y), row-major
    function automatic logic [ADDR_W-1:0] pixel_addr(input logic [Y_W-1:0] y,
                                                     input logic [X_W-1:0] x);
        return ADDR_W'(y) * ADDR_W'(H_RES) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/fb_fill_arbiter_if.sv
// rtl/fb_fill_arbiter_if.sv - processor, fill-command and RAM port-A signals of the fill arbiter
interface fb_fill_arbiter_if;
    import fb_pkg::*;

    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_we;
    logic              cpu_re;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [X_W-1:0]    cmd_x;
    logic [Y_W-1:0]    cmd_y;
    logic [X_W-1:0]    cmd_w;
    logic [Y_W-1:0]    cmd_h;
    logic [DATA_W-1:0] cmd_index;

    logic              busy;
    logic              done;
    logic              cmd_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;

    modport master (
        output cpu_addr, cpu_wdata, cpu_we, cpu_re,
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_index,
        input  cmd_ready, busy, done, cmd_err,
        input  mem_addr, mem_data, mem_wren
    );

    modport slave (
        input  cpu_addr, cpu_wdata, cpu_we, cpu_re,
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_index,
        output cmd_ready, busy, done, cmd_err,
        output mem_addr, mem_data, mem_wren
    );

endinterface

// File: rtl/fb_rect_walker.sv
// rtl/fb_rect_walker.sv - row-major rectangle address walker (row_base, col, row)
module fb_rect_walker
    import fb_pkg::*;
(
    input  logic              processorClk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_base,
    input  logic [X_W-1:0]    load_w,
    input  logic [Y_W-1:0]    load_h,
    input  logic              step,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    logic [ADDR_W-1:0] row_base;
    logic [X_W-1:0]    col;
    logic [X_W-1:0]    w_q;
    logic [Y_W-1:0]    row;
    logic [Y_W-1:0]    h_q;
    logic              col_last;
    logic              row_last;

    assign col_last = (col == w_q - X_W'(1));
    assign row_last = (row == h_q - Y_W'(1));
    assign addr     = row_base + ADDR_W'(col);
    assign last     = col_last && row_last;

    // Load the rectangle origin/size, then advance one pixel per step, wrapping to the next line
    always_ff @(posedge processorClk or posedge reset) begin
        if (reset) begin
            row_base <= '0;
            col      <= '0;
            row      <= '0;
            w_q      <= '0;
            h_q      <= '0;
        end else if (load) begin
            row_base <= load_base;
            col      <= '0;
            row      <= '0;
            w_q      <= load_w;
            h_q      <= load_h;
        end else if (step) begin
            if (col_last) begin
                row_base <= row_base + ADDR_W'(H_RES);
                col      <= '0;
                row      <= row + Y_W'(1);
            end else begin
                col      <= col + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/fb_fill_arbiter.sv
// rtl/fb_fill_arbiter.sv - framebuffer port-A arbiter: processor priority over rectangle fill; FB_FILL_CLIP_EN clips instead of rejecting
module fb_fill_arbiter
    import fb_pkg::*;
(
    input  logic             processorClk,
    input  logic             reset,
    fb_fill_arbiter_if.slave bus
);

    fill_state_e       state_q;
    fill_state_e       state_d;

    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [X_W-1:0]    w_q;
    logic [Y_W-1:0]    h_q;
    logic [DATA_W-1:0] idx_q;
    logic              rej_q;

    logic              accept;
    logic              cpu_req;
    logic              step;
    logic              setup_load;
    logic              rej;
    logic              empty;
    logic [X_W-1:0]    eff_w;
    logic [Y_W-1:0]    eff_h;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] walk_addr;
    logic              walk_last;
    logic              unused_cpu_addr_hi;

    assign unused_cpu_addr_hi = ^bus.cpu_addr[31:ADDR_W];

    assign cpu_req    = bus.cpu_we | bus.cpu_re;
    assign accept     = (state_q == FILL_IDLE) && bus.cmd_valid;
    assign setup_load = (state_q == FILL_SETUP);
    assign step       = (state_q == FILL_RUN) && !cpu_req;
    assign base_addr  = pixel_addr(y_q, x_q);

`ifdef FB_FILL_CLIP_EN
    logic           x_off;
    logic           y_off;
    logic [X_W-1:0] x_room;
    logic [Y_W-1:0] y_room;

    // Off-screen origins give an empty fill; otherwise the size is trimmed to the screen edge
    assign x_off  = (x_q >= X_W'(H_RES));
    assign y_off  = (y_q >= Y_W'(V_RES));
    assign x_room = X_W'(H_RES) - x_q;
    assign y_room = Y_W'(V_RES) - y_q;
    assign eff_w  = x_off ? '0 : ((w_q > x_room) ? x_room : w_q);
    assign eff_h  = y_off ? '0 : ((h_q > y_room) ? y_room : h_q);
    assign rej    = 1'b0;
`else
    logic [X_W:0] x_end;
    logic [Y_W:0] y_end;

    // One extra bit so x+w and y+h cannot overflow before the bound compare
    assign x_end = {1'b0, x_q} + {1'b0, w_q};
    assign y_end = {1'b0, y_q} + {1'b0, h_q};
    assign rej   = (x_end > (X_W+1)'(H_RES)) || (y_end > (Y_W+1)'(V_RES));
    assign eff_w = w_q;
    assign eff_h = h_q;
`endif

    assign empty = (eff_w == '0) || (eff_h == '0) || rej;

    // Latch the command on acceptance; capture the reject verdict during SETUP
    always_ff @(posedge processorClk or posedge reset) begin
        if (reset) begin
            x_q   <= '0;
            y_q   <= '0;
            w_q   <= '0;
            h_q   <= '0;
            idx_q <= '0;
            rej_q <= 1'b0;
        end else begin
            if (accept) begin
                x_q   <= bus.cmd_x;
                y_q   <= bus.cmd_y;
                w_q   <= bus.cmd_w;
                h_q   <= bus.cmd_h;
                idx_q <= bus.cmd_index;
            end
            if (setup_load) begin
                rej_q <= rej;
            end
        end
    end

    // Fill FSM state register
    always_ff @(posedge processorClk or posedge reset) begin
        if (reset) begin
            state_q <= FILL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fill FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL_IDLE:  if (accept) state_d = FILL_SETUP;
            FILL_SETUP: state_d = empty ? FILL_DONE : FILL_RUN;
            FILL_RUN:   if (step && walk_last) state_d = FILL_DONE;
            FILL_DONE:  state_d = FILL_IDLE;
            default:    state_d = FILL_IDLE;
        endcase
    end

    assign bus.cmd_ready = (state_q == FILL_IDLE);
    assign bus.busy      = (state_q != FILL_IDLE);
    assign bus.done      = (state_q == FILL_DONE);
    assign bus.cmd_err   = (state_q == FILL_DONE) && rej_q;

    // Port mux: processor first, then the fill engine, otherwise an idle read address
    always_comb begin
        bus.mem_addr = bus.cpu_addr[ADDR_W-1:0];
        bus.mem_data = '0;
        bus.mem_wren = 1'b0;
        if (cpu_req) begin
            bus.mem_data = bus.cpu_wdata;
            bus.mem_wren = bus.cpu_we;
        end else if (state_q == FILL_RUN) begin
            bus.mem_addr = walk_addr;
            bus.mem_data = idx_q;
            bus.mem_wren = 1'b1;
        end
    end

    fb_rect_walker u_walker (
        .processorClk (processorClk),
        .reset        (reset),
        .load         (setup_load),
        .load_base    (base_addr),
        .load_w       (eff_w),
        .load_h       (eff_h),
        .step         (step),
        .addr         (walk_addr),
        .last         (walk_last)
    );

endmodule

// File: tb/tb_fb_fill_arbiter.sv
// tb/tb_fb_fill_arbiter.sv - directed self-checking bench for fb_fill_arbiter
module tb_fb_fill_arbiter;
    import fb_pkg::*;

    logic clk;
    logic rst;

    fb_fill_arbiter_if bus();

    fb_fill_arbiter dut (
        .processorClk (clk),
        .reset        (rst),
        .bus          (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] wr_q[$];
    logic [63:0] exp_q[$];
    int          done_q[$];
    logic        err_q[$];
    logic        ready_hist[64];
    logic        busy_hist[64];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [63:0] pack_wr(input int cyc, input logic [ADDR_W-1:0] a,
                                            input logic [DATA_W-1:0] d);
        logic [11:0] c;
        c = cyc[11:0];
        return {1'b0, c, a, d};
    endfunction

    task automatic clear_log();
        wr_q.delete();
        exp_q.delete();
        done_q.delete();
        err_q.delete();
        for (int i = 0; i < 64; i++) begin
            ready_hist[i] = 1'b0;
            busy_hist[i]  = 1'b0;
        end
    endtask

    // Inputs are already set for this cycle; sample at the falling edge, then advance
    task automatic step_cycle(input int cyc);
        @(negedge clk);
        if (bus.mem_wren) wr_q.push_back(pack_wr(cyc, bus.mem_addr, bus.mem_data));
        if (bus.done) begin
            done_q.push_back(cyc);
            err_q.push_back(bus.cmd_err);
        end
        if (cyc < 64) begin
            ready_hist[cyc] = bus.cmd_ready;
            busy_hist[cyc]  = bus.busy;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input int x, input int y, input int w, input int h, input int idx);
        bus.cmd_x     = x[X_W-1:0];
        bus.cmd_y     = y[Y_W-1:0];
        bus.cmd_w     = w[X_W-1:0];
        bus.cmd_h     = h[Y_W-1:0];
        bus.cmd_index = idx;
    endtask

    // Offer one command at cycle 0; cpu writes addr 100 / data 9 during cycles cpu_lo..cpu_hi
    task automatic run_cmd(input int x, input int y, input int w, input int h, input int idx,
                           input int ncyc, input int cpu_lo, input int cpu_hi);
        clear_log();
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            bus.cmd_valid = (cyc == 0);
            if (cyc == 0) set_cmd(x, y, w, h, idx);
            bus.cpu_we    = (cyc >= cpu_lo) && (cyc <= cpu_hi);
            bus.cpu_addr  = bus.cpu_we ? 32'd100 : 32'd0;
            bus.cpu_wdata = bus.cpu_we ? 32'd9 : 32'd0;
            step_cycle(cyc);
        end
        bus.cpu_we = 1'b0;
    endtask

    task automatic compare_writes(input string tag);
        check_val({tag, "_nwr"}, 64'(wr_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            check_val($sformatf("%s_wr%0d", tag, i), wr_q[i], exp_q[i]);
        end
    endtask

    task automatic compare_done(input string tag, input int exp_cyc, input logic exp_err);
        check_val({tag, "_ndone"}, 64'(done_q.size()), 64'd1);
        if (done_q.size() > 0) begin
            check_val({tag, "_done_cyc"}, 64'(done_q[0]), 64'(exp_cyc));
            check_val({tag, "_err"}, 64'(err_q[0]), 64'(exp_err));
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_we    = 1'b0;
        bus.cpu_re    = 1'b0;
        bus.cmd_valid = 1'b0;
        set_cmd(0, 0, 0, 0, 0);
        clear_log();

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_ready", 64'(bus.cmd_ready), 64'd1);
        check_val("rst_busy",  64'(bus.busy),      64'd0);
        check_val("rst_done",  64'(bus.done),      64'd0);
        check_val("rst_err",   64'(bus.cmd_err),   64'd0);
        check_val("rst_wren",  64'(bus.mem_wren),  64'd0);
        check_val("rst_addr",  64'(bus.mem_addr),  64'd0);
        check_val("rst_data",  64'(bus.mem_data),  64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Test 1: 4x2 at origin, index 5
        run_cmd(0, 0, 4, 2, 5, 14, -1, -1);
        exp_q.push_back(pack_wr(2, 19'd0,   32'd5));
        exp_q.push_back(pack_wr(3, 19'd1,   32'd5));
        exp_q.push_back(pack_wr(4, 19'd2,   32'd5));
        exp_q.push_back(pack_wr(5, 19'd3,   32'd5));
        exp_q.push_back(pack_wr(6, 19'd640, 32'd5));
        exp_q.push_back(pack_wr(7, 19'd641, 32'd5));
        exp_q.push_back(pack_wr(8, 19'd642, 32'd5));
        exp_q.push_back(pack_wr(9, 19'd643, 32'd5));
        compare_writes("t1");
        compare_done("t1", 10, 1'b0);
        check_val("t1_ready_c0", 64'(ready_hist[0]), 64'd1);
        check_val("t1_ready_c1", 64'(ready_hist[1]), 64'd0);
        check_val("t1_busy_c1",  64'(busy_hist[1]),  64'd1);
        check_val("t1_busy_c11", 64'(busy_hist[11]), 64'd0);

        // Test 2: processor writes in cycles 3-4 stall the fill for two cycles
        run_cmd(0, 0, 4, 2, 5, 16, 3, 4);
        exp_q.push_back(pack_wr(2,  19'd0,   32'd5));
        exp_q.push_back(pack_wr(3,  19'd100, 32'd9));
        exp_q.push_back(pack_wr(4,  19'd100, 32'd9));
        exp_q.push_back(pack_wr(5,  19'd1,   32'd5));
        exp_q.push_back(pack_wr(6,  19'd2,   32'd5));
        exp_q.push_back(pack_wr(7,  19'd3,   32'd5));
        exp_q.push_back(pack_wr(8,  19'd640, 32'd5));
        exp_q.push_back(pack_wr(9,  19'd641, 32'd5));
        exp_q.push_back(pack_wr(10, 19'd642, 32'd5));
        exp_q.push_back(pack_wr(11, 19'd643, 32'd5));
        compare_writes("t2");
        compare_done("t2", 12, 1'b0);

        // Test 3: zero width
        run_cmd(5, 5, 0, 7, 3, 6, -1, -1);
        compare_writes("t3");
        compare_done("t3", 2, 1'b0);

        // Test 4: rectangle crossing the bottom-right screen corner
        run_cmd(638, 479, 4, 2, 6, 8, -1, -1);
`ifdef FB_FILL_CLIP_EN
        exp_q.push_back(pack_wr(2, 19'd307198, 32'd6));
        exp_q.push_back(pack_wr(3, 19'd307199, 32'd6));
        compare_writes("t4");
        compare_done("t4", 4, 1'b0);
`else
        compare_writes("t4");
        compare_done("t4", 2, 1'b1);
`endif

        // Rectangle ending exactly on the screen edge is legal in both builds
        run_cmd(636, 478, 4, 2, 1, 14, -1, -1);
        exp_q.push_back(pack_wr(2, 19'd306556, 32'd1));
        exp_q.push_back(pack_wr(3, 19'd306557, 32'd1));
        exp_q.push_back(pack_wr(4, 19'd306558, 32'd1));
        exp_q.push_back(pack_wr(5, 19'd306559, 32'd1));
        exp_q.push_back(pack_wr(6, 19'd307196, 32'd1));
        exp_q.push_back(pack_wr(7, 19'd307197, 32'd1));
        exp_q.push_back(pack_wr(8, 19'd307198, 32'd1));
        exp_q.push_back(pack_wr(9, 19'd307199, 32'd1));
        compare_writes("edge");
        compare_done("edge", 10, 1'b0);

        // Test 5: cmd_valid held through a fill; second command waits for IDLE
        clear_log();
        for (int cyc = 0; cyc < 14; cyc++) begin
            bus.cmd_valid = (cyc <= 5);
            if (cyc == 0) set_cmd(10, 2, 2, 1, 3);
            else          set_cmd(20, 3, 1, 2, 7);
            step_cycle(cyc);
        end
        bus.cmd_valid = 1'b0;
        exp_q.push_back(pack_wr(2, 19'd1290, 32'd3));
        exp_q.push_back(pack_wr(3, 19'd1291, 32'd3));
        exp_q.push_back(pack_wr(7, 19'd1940, 32'd7));
        exp_q.push_back(pack_wr(8, 19'd2580, 32'd7));
        compare_writes("t5");
        check_val("t5_ndone", 64'(done_q.size()), 64'd2);
        if (done_q.size() == 2) begin
            check_val("t5_done1", 64'(done_q[0]), 64'd4);
            check_val("t5_done2", 64'(done_q[1]), 64'd9);
        end
        check_val("t5_ready_c0", 64'(ready_hist[0]), 64'd1);
        check_val("t5_ready_c2", 64'(ready_hist[2]), 64'd0);
        check_val("t5_ready_c4", 64'(ready_hist[4]), 64'd0);
        check_val("t5_ready_c5", 64'(ready_hist[5]), 64'd1);
        check_val("t5_ready_c6", 64'(ready_hist[6]), 64'd0);

        // Test 6: one-cycle reset mid-fill aborts without a done pulse
        clear_log();
        for (int cyc = 0; cyc < 4; cyc++) begin
            bus.cmd_valid = (cyc == 0);
            if (cyc == 0) set_cmd(0, 0, 4, 2, 5);
            step_cycle(cyc);
        end
        rst = 1'b1;
        #1;
        check_val("t6_wren", 64'(bus.mem_wren),  64'd0);
        check_val("t6_busy", 64'(bus.busy),      64'd0);
        check_val("t6_rdy",  64'(bus.cmd_ready), 64'd1);
        step_cycle(4);
        rst = 1'b0;
        for (int cyc = 5; cyc < 10; cyc++) step_cycle(cyc);
        exp_q.push_back(pack_wr(2, 19'd0, 32'd5));
        exp_q.push_back(pack_wr(3, 19'd1, 32'd5));
        compare_writes("t6");
        check_val("t6_ndone", 64'(done_q.size()), 64'd0);

        run_cmd(1, 1, 1, 1, 2, 6, -1, -1);
        exp_q.push_back(pack_wr(2, 19'd641, 32'd2));
        compare_writes("t6b");
        compare_done("t6b", 3, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
